// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Latches rising edges on CHANNELS single-bit lines as pending events and
// serialises them onto one valid/ready channel with round-robin fairness.
// A sticky per-channel overflow flag records edges lost while unserved.
// All outputs come straight from registers.
module edge_event_arbiter #(
  parameter int CHANNELS    = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [CHANNELS-1:0]    signals_i,
  output logic                   event_valid_o,
  input  logic                   event_ready_i,
  output logic [INDEX_WIDTH-1:0] event_index_o,
  output logic [CHANNELS-1:0]    pending_o,
  output logic [CHANNELS-1:0]    overflow_o,
  input  logic [CHANNELS-1:0]    overflow_clear_i
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [CHANNELS-1:0]    previous_q;
  logic [CHANNELS-1:0]    pending_q, pending_d;
  logic [CHANNELS-1:0]    overflow_q, overflow_d;
  logic                   valid_q, valid_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [INDEX_WIDTH-1:0] pointer_q, pointer_d;

  logic [CHANNELS-1:0]    edge_s;
  logic                   fire_s;
  logic [CHANNELS-1:0]    consumed_s;
  logic [CHANNELS-1:0]    candidate_s;
  logic                   any_candidate_s;
  logic [INDEX_WIDTH-1:0] selected_s;

  // First set bit of cand found by searching upward from ptr, wrapping to 0.
  function automatic logic [INDEX_WIDTH-1:0] rr_pick(
    input logic [CHANNELS-1:0]    cand,
    input logic [INDEX_WIDTH-1:0] ptr
  );
    logic [INDEX_WIDTH-1:0] pick;
    logic [INDEX_WIDTH-1:0] pos_idx;
    logic                   found;
    int                     pos;
    pick  = ptr;
    found = 1'b0;
    for (int off = 0; off < CHANNELS; off++) begin
      pos     = (int'(ptr) + off) % CHANNELS;
      pos_idx = INDEX_WIDTH'(pos);
      if (!found && cand[pos_idx]) begin
        pick  = pos_idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // Edge detection, handshake decode and the arbitration candidate set.
  always_comb begin
    edge_s     = signals_i & ~previous_q;
    fire_s     = valid_q & event_ready_i;
    consumed_s = {CHANNELS{1'b0}};
    if (fire_s) begin
      consumed_s = {{(CHANNELS-1){1'b0}}, 1'b1} << index_q;
    end else begin
      consumed_s = {CHANNELS{1'b0}};
    end
    // The channel being consumed this cycle must not be re-offered at once,
    // even if a fresh edge re-arms its pending bit.
    if (state_q == OFFER) begin
      candidate_s = pending_q & ~consumed_s;
    end else begin
      candidate_s = pending_q;
    end
    any_candidate_s = |candidate_s;
    selected_s      = rr_pick(candidate_s, pointer_q);
  end

  // Pending, overflow and pointer next-state; a new edge outranks consumption.
  always_comb begin
    pending_d  = edge_s | (pending_q & ~consumed_s);
    overflow_d = (overflow_q & ~overflow_clear_i) | (edge_s & pending_q & ~consumed_s);
    if (fire_s) begin
      if (index_q == INDEX_WIDTH'(CHANNELS - 1)) begin
        pointer_d = {INDEX_WIDTH{1'b0}};
      end else begin
        pointer_d = index_q + INDEX_WIDTH'(1);
      end
    end else begin
      pointer_d = pointer_q;
    end
  end

  // FSM next-state: offer while anything is left to serve.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_candidate_s) state_d = OFFER;
        else                 state_d = IDLE;
      end
      OFFER: begin
        if (fire_s && !any_candidate_s) state_d = IDLE;
        else                            state_d = OFFER;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: load a new offer, hold it until accepted, or drop valid.
  always_comb begin
    valid_d = valid_q;
    index_d = index_q;
    case (state_q)
      IDLE: begin
        if (any_candidate_s) begin
          valid_d = 1'b1;
          index_d = selected_s;
        end else begin
          valid_d = 1'b0;
          index_d = index_q;
        end
      end
      OFFER: begin
        if (!fire_s) begin
          valid_d = valid_q;
          index_d = index_q;
        end else if (any_candidate_s) begin
          valid_d = 1'b1;
          index_d = selected_s;
        end else begin
          valid_d = 1'b0;
          index_d = index_q;
        end
      end
      default: begin
        valid_d = 1'b0;
        index_d = index_q;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      previous_q <= {CHANNELS{1'b0}};
      pending_q  <= {CHANNELS{1'b0}};
      overflow_q <= {CHANNELS{1'b0}};
      valid_q    <= 1'b0;
      index_q    <= {INDEX_WIDTH{1'b0}};
      pointer_q  <= {INDEX_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      previous_q <= signals_i;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      index_q    <= index_d;
      pointer_q  <= pointer_d;
    end
  end

  assign event_valid_o = valid_q;
  assign event_index_o = index_q;
  assign pending_o     = pending_q;
  assign overflow_o    = overflow_q;

endmodule
